shift_issue_stage: RTL and testbench
====================================

// Module: shift_issue_stage
// PURPOSE
//  Pipeline stage directly upstream of the 16-bit combinational shifter. Takes decoded shift
//  instructions plus register-file operands and selects the 4-bit shift amount (immediate or
//  rt[3:0]). Registers operand, amount and destination behind a 2-entry valid/ready skid buffer,
//  so the shifter sees stable inputs for a full cycle. Non-shift opcodes are consumed and dropped.
// PARAMETERS
//  DW      16  datapath width (shifter operand width)
//  SAW     4   shift-amount width, log2(DW)
//  RDW     3   destination register index width
//  CNTW    16  stall-counter width
// PORTS
//  clk            in   1     single clock, all state on rising edge
//  rst_n          in   1     asynchronous reset, active-low; release synchronised externally
//  flush          in   1     synchronous pipeline flush
//  in_valid       in   1     upstream beat valid
//  in_ready       out  1     stage can accept; registered (== !skid_valid)
//  in_opcode      in   4     decoded opcode (shift_pkg constants)
//  in_rs_val      in   DW    operand to be shifted
//  in_rt_val      in   DW    register shift-amount source
//  in_imm         in   SAW   immediate shift amount
//  in_use_imm     in   1     1: amount=in_imm, 0: amount=in_rt_val[SAW-1:0]
//  in_rd          in   RDW   destination register
//  out_valid      out  1     beat presented to shifter/writeback
//  out_ready      in   1     downstream accepts
//  out_a          out  DW    operand to shifter A
//  out_shamt      out  SAW   shift amount to shifter
//  out_op         out  2     SHOP_SLL/SHOP_SRL/SHOP_SRA
//  out_ovf        out  1     register amount had in_rt_val[DW-1:SAW]!=0; result must be forced 0
//  out_rd         out  RDW   destination register
//  stall_cnt      out  CNTW  cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): main/skid valid=0, in_ready=1, all data outputs 0, stall_cnt=0.
//  Accept: in_valid && in_ready && !flush. Shift opcode -> enqueue; other opcode -> consume, discard.
//  Latency 1: beat accepted in cycle N drives out_valid in cycle N+1. Throughput 1 beat/cycle.
//  Main reg empty or draining (out_ready=1): accepted beat loads main reg.
//  Main reg full and out_ready=0: accepted beat loads skid reg; in_ready drops next cycle.
//  On main drain with skid full: skid moves to main; in_ready returns 1 next cycle.
//  Order preserved strictly; no beat lost or duplicated.
//  out_* held stable while out_valid && !out_ready (downstream may sample any cycle).
//  Amount select: in_use_imm ? in_imm : in_rt_val[SAW-1:0]. out_ovf=0 whenever in_use_imm=1.
//  out_op from opcode: OP_SLL->SHOP_SLL, OP_SRL->SHOP_SRL, OP_SRA->SHOP_SRA.
//  flush=1: both entries invalidated next edge, in_ready=1 next cycle; same-cycle input beat
//   is NOT accepted (flush beats in_valid); same-cycle downstream handshake still completes.
//  stall_cnt increments each cycle out_valid && !out_ready, holds at 2^CNTW-1; flush does not clear it.
//  Reset asserted mid-transfer: all in-flight beats dropped, outputs to reset values immediately.
// STRUCTURE
//  shift_pkg: OP_SLL=4'h4, OP_SRL=4'h5, OP_SRA=4'h6; SHOP_SLL=2'd0, SHOP_SRL=2'd1,
//   SHOP_SRA=2'd2; typedef shift_beat_t {a, shamt, op, ovf, rd}; is_shift_op() function.
//  One sub-module: skid_buffer (generic 2-entry valid/ready, width param, flush input) carrying
//   shift_beat_t; top does decode/amount select and stall counter.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1, out_a=0, stall_cnt=0 immediately.
//  2 OP_SLL, rs=16'h00F1, imm=4'd3, use_imm=1, out_ready=1 -> next cycle out_a=16'h00F1,
//    out_shamt=3, out_op=SHOP_SLL, out_ovf=0; shifter output 16'h0788.
//  3 use_imm=0, rt=16'h0012 -> out_shamt=4'h2, out_ovf=1; rt=16'h000F -> shamt=15, ovf=0.
//  4 Back-pressure: out_ready=0, send beats A,B -> in_ready=0 after B, A held 5 cycles,
//    stall_cnt=5; release -> A then B on consecutive cycles, in_ready back to 1.
//  5 Opcode 4'h0 with in_valid=1 -> in_ready stays 1, nothing on out_valid.
//  6 flush with main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    flushed-cycle input never appears; stall_cnt unchanged.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared opcode constants, shifter op encodings and the beat format carried
// from the issue stage to the 16-bit shifter.
package shift_pkg;

  localparam int SH_DW  = 16;
  localparam int SH_SAW = 4;
  localparam int SH_RDW = 3;

  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_SRA = 4'h6;

  localparam logic [1:0] SHOP_SLL = 2'd0;
  localparam logic [1:0] SHOP_SRL = 2'd1;
  localparam logic [1:0] SHOP_SRA = 2'd2;

  typedef struct packed {
    logic [SH_DW-1:0]  a;
    logic [SH_SAW-1:0] shamt;
    logic [1:0]        op;
    logic              ovf;
    logic [SH_RDW-1:0] rd;
  } shift_beat_t;

  function automatic logic is_shift_op(input logic [3:0] opcode);
    return (opcode == OP_SLL) || (opcode == OP_SRL) || (opcode == OP_SRA);
  endfunction

  function automatic logic [1:0] shop_of(input logic [3:0] opcode);
    logic [1:0] shop;
    shop = SHOP_SLL;
    case (opcode)
      OP_SRL:  shop = SHOP_SRL;
      OP_SRA:  shop = SHOP_SRA;
      default: shop = SHOP_SLL;
    endcase
    return shop;
  endfunction

endpackage

// File: rtl/shift_issue_stage_skid.sv
// Generic 2-entry valid/ready skid buffer: a main output register plus one
// overflow register, so in_ready can be a pure register output.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         main_free;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid && !skid_valid && !flush;
  assign main_free = !main_valid || out_ready;

  // The skid entry always has priority into main so ordering is preserved;
  // while skid is full in_ready is low, so no new beat can compete with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Issue stage ahead of the 16-bit shifter: decodes the shift op, selects the
// shift amount, flags oversized register amounts and counts downstream stalls.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int DW   = SH_DW,
  parameter int SAW  = SH_SAW,
  parameter int RDW  = SH_RDW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_opcode,
  input  logic [DW-1:0]   in_rs_val,
  input  logic [DW-1:0]   in_rt_val,
  input  logic [SAW-1:0]  in_imm,
  input  logic            in_use_imm,
  input  logic [RDW-1:0]  in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_a,
  output logic [SAW-1:0]  out_shamt,
  output logic [1:0]      out_op,
  output logic            out_ovf,
  output logic [RDW-1:0]  out_rd,
  output logic [CNTW-1:0] stall_cnt
);

  shift_beat_t in_beat;
  shift_beat_t out_beat;
  logic        enq_valid;

  // Non-shift opcodes still see in_ready high, so they are consumed upstream
  // but never reach the buffer.
  always_comb begin
    in_beat       = '0;
    in_beat.a     = in_rs_val;
    in_beat.shamt = in_use_imm ? in_imm : in_rt_val[SAW-1:0];
    in_beat.op    = shop_of(in_opcode);
    in_beat.ovf   = !in_use_imm && (|in_rt_val[DW-1:SAW]);
    in_beat.rd    = in_rd;
  end

  assign enq_valid = in_valid && is_shift_op(in_opcode);

  skid_buffer #(
    .W($bits(shift_beat_t))
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (enq_valid),
    .in_ready (in_ready),
    .in_data  (in_beat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_beat)
  );

  assign out_a     = out_beat.a;
  assign out_shamt = out_beat.shamt;
  assign out_op    = out_beat.op;
  assign out_ovf   = out_beat.ovf;
  assign out_rd    = out_beat.rd;

  // Saturating stall counter; deliberately left untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage with hand-computed
// expected values.
module tb_shift_issue_stage;
  import shift_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_rs_val;
  logic [15:0] in_rt_val;
  logic [3:0]  in_imm;
  logic        in_use_imm;
  logic [2:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [3:0]  out_shamt;
  logic [1:0]  out_op;
  logic        out_ovf;
  logic [2:0]  out_rd;
  logic [15:0] stall_cnt;

  int passCount;
  int checkCount;

  shift_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rs_val (in_rs_val),
    .in_rt_val (in_rt_val),
    .in_imm    (in_imm),
    .in_use_imm(in_use_imm),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_shamt (out_shamt),
    .out_op    (out_op),
    .out_ovf   (out_ovf),
    .out_rd    (out_rd),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] opc, input logic [15:0] rs,
                               input logic [15:0] rt, input logic [3:0] imm,
                               input logic useImm, input logic [2:0] rd);
    in_valid   = v;
    in_opcode  = opc;
    in_rs_val  = rs;
    in_rt_val  = rt;
    in_imm     = imm;
    in_use_imm = useImm;
    in_rd      = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b0, 3'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-stream while a beat is stalled
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_SLL, 16'h1234, 16'h0, 4'd1, 1'b1, 3'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("pre_reset_stall", {16'd0, stall_cnt}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_a", {16'd0, out_a}, 32'd0);
    checkOutput("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Immediate amount, SLL
    applyStimulus(1'b1, OP_SLL, 16'h00F1, 16'h0000, 4'd3, 1'b1, 3'd2);
    tick();
    in_valid = 1'b0;
    checkOutput("sll_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("sll_a", {16'd0, out_a}, 32'h00F1);
    checkOutput("sll_shamt", {28'd0, out_shamt}, 32'd3);
    checkOutput("sll_op", {30'd0, out_op}, {30'd0, SHOP_SLL});
    checkOutput("sll_ovf", {31'd0, out_ovf}, 32'd0);
    checkOutput("sll_rd", {29'd0, out_rd}, 32'd2);
    checkOutput("sll_result", {16'd0, 16'(out_a << out_shamt)}, 32'h0788);

    // Register amount: oversized, max legal, and immediate ignoring rt
    applyStimulus(1'b1, OP_SRL, 16'h8000, 16'h0012, 4'd0, 1'b0, 3'd3);
    tick();
    checkOutput("rt_ovf_shamt", {28'd0, out_shamt}, 32'd2);
    checkOutput("rt_ovf_flag", {31'd0, out_ovf}, 32'd1);
    checkOutput("rt_ovf_op", {30'd0, out_op}, {30'd0, SHOP_SRL});
    applyStimulus(1'b1, OP_SRA, 16'h8000, 16'h000F, 4'd9, 1'b0, 3'd4);
    tick();
    checkOutput("rt15_shamt", {28'd0, out_shamt}, 32'd15);
    checkOutput("rt15_ovf", {31'd0, out_ovf}, 32'd0);
    checkOutput("rt15_op", {30'd0, out_op}, {30'd0, SHOP_SRA});
    checkOutput("rt15_rd", {29'd0, out_rd}, 32'd4);
    applyStimulus(1'b1, OP_SLL, 16'h0001, 16'hFFFF, 4'd5, 1'b1, 3'd0);
    tick();
    checkOutput("imm_noovf_shamt", {28'd0, out_shamt}, 32'd5);
    checkOutput("imm_noovf_ovf", {31'd0, out_ovf}, 32'd0);
    in_valid = 1'b0;
    tick();
    checkOutput("drained_valid", {31'd0, out_valid}, 32'd0);

    // Back-pressure: A in main, B in skid, A held five stall cycles
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_SLL, 16'hAAAA, 16'h0, 4'd1, 1'b1, 3'd5);
    tick();
    applyStimulus(1'b1, OP_SRL, 16'hBBBB, 16'h0, 4'd2, 1'b1, 3'd6);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_hold_a", {16'd0, out_a}, 32'hAAAA);
      tick();
    end
    checkOutput("bp_stall_cnt", {16'd0, stall_cnt}, 32'd5);
    checkOutput("bp_still_a", {16'd0, out_a}, 32'hAAAA);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_b_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("bp_b_a", {16'd0, out_a}, 32'hBBBB);
    checkOutput("bp_b_rd", {29'd0, out_rd}, 32'd6);
    checkOutput("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("bp_empty", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_stall_hold", {16'd0, stall_cnt}, 32'd5);

    // Non-shift opcode is consumed and dropped
    applyStimulus(1'b1, 4'h0, 16'h5555, 16'h0, 4'd1, 1'b1, 3'd1);
    checkOutput("nop_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("nop_in_ready_after", {31'd0, in_ready}, 32'd1);
    checkOutput("nop_no_valid", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full and a beat offered
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_SLL, 16'hCCCC, 16'h0, 4'd1, 1'b1, 3'd1);
    tick();
    applyStimulus(1'b1, OP_SLL, 16'hDDDD, 16'h0, 4'd1, 1'b1, 3'd2);
    tick();
    checkOutput("fl_pre_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("fl_pre_stall", {16'd0, stall_cnt}, 32'd6);
    applyStimulus(1'b1, OP_SLL, 16'hEEEE, 16'h0, 4'd1, 1'b1, 3'd3);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("fl_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("fl_in_ready", {31'd0, in_ready}, 32'd1);
    // The flush cycle itself was still a stall cycle; flush must not clear the count
    checkOutput("fl_stall_kept", {16'd0, stall_cnt}, 32'd7);
    tick();
    checkOutput("fl_no_ghost", {31'd0, out_valid}, 32'd0);

    // Flush beats in_valid even when the stage is ready
    applyStimulus(1'b1, OP_SRA, 16'hF00F, 16'h0, 4'd4, 1'b1, 3'd7);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("fl_ready_drop", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("fl_ready_drop2", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
